// File: rtl/fifo_serial_tx.sv
// FIFO consumer that pops one byte per frame and shifts it out as 8N1 serial.
// Each frame begins with a settle cycle so a registered-read FIFO presents fresh data before the pop.
module fifo_serial_tx #(
   parameter int CLK_FREQ  = 48_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_empty,
   input  logic [7:0] i_data,
   output logic       o_rd,
   output logic       o_tx,
   output logic       o_busy
);

   localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_STOP   = 3'd5
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic [2:0]       idx_r;
   logic [2:0]       idx_s;
   logic [7:0]       shift_r;
   logic [7:0]       shift_s;
   logic             tx_r;
   logic             tx_s;
   logic             rd_r;
   logic             busy_r;
   logic             bit_end_s;

   assign bit_end_s = (cnt_r == CNT_LAST);

   // Next-state, baud counter, bit index and shift register update.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      shift_s = shift_r;
      case (state_r)
         ST_IDLE: begin
            cnt_s = CNT_ZERO;
            idx_s = 3'd0;
            if (!i_empty) begin
               state_s = ST_SETTLE;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            cnt_s   = CNT_ZERO;
            state_s = ST_LOAD;
         end
         ST_LOAD: begin
            // The pop and the capture happen on the same edge.
            cnt_s   = CNT_ZERO;
            idx_s   = 3'd0;
            shift_s = i_data;
            state_s = ST_START;
         end
         ST_START: begin
            if (bit_end_s) begin
               cnt_s   = CNT_ZERO;
               state_s = ST_DATA;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               cnt_s = CNT_ZERO;
               if (idx_r == 3'd7) begin
                  state_s = ST_STOP;
               end else begin
                  idx_s   = idx_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         ST_STOP: begin
            if (bit_end_s) begin
               cnt_s   = CNT_ZERO;
               state_s = ST_IDLE;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = CNT_ZERO;
            idx_s   = 3'd0;
            shift_s = 8'h00;
         end
      endcase
   end

   // Line level for the upcoming cycle, derived from the next state so o_tx can be registered.
   always_comb begin
      tx_s = 1'b1;
      case (state_s)
         ST_START: tx_s = 1'b0;
         ST_DATA:  tx_s = shift_s[0];
         default:  tx_s = 1'b1;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
         rd_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
         rd_r    <= (state_s == ST_LOAD);
         busy_r  <= (state_s != ST_IDLE);
      end
   end

   assign o_tx   = tx_r;
   assign o_rd   = rd_r;
   assign o_busy = busy_r;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a FIFO model feeds a fast-baud instance that is checked every cycle
// against a frame-timeline model; a default-baud instance is checked for frame length.
module tb_fifo_serial_tx;

   localparam int BD = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // FIFO model: write port driven by the bench, read data either combinational or registered
   logic [7:0] mem [16] = '{default: 8'hEE};
   logic [3:0] wptr     = 4'd0;
   logic [3:0] rptr     = 4'd0;
   logic [7:0] data_r   = 8'h00;
   logic       wr_en    = 1'b0;
   logic [7:0] wr_byte  = 8'h00;
   logic       reg_mode = 1'b0;
   logic       f_empty;
   logic [7:0] f_data;
   logic       rd1, tx1, busy1;

   assign f_empty = (wptr == rptr);
   assign f_data  = reg_mode ? data_r : mem[rptr];

   always @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= wr_byte;
         wptr      <= wptr + 4'd1;
      end
      if (rd1) rptr <= rptr + 4'd1;
      data_r <= mem[rptr];
   end

   fifo_serial_tx #(.BAUD_DIV(BD)) dut (
      .i_clk(clk), .i_rst(rst), .i_empty(f_empty), .i_data(f_data),
      .o_rd(rd1), .o_tx(tx1), .o_busy(busy1)
   );

   logic       empty_d = 1'b1;
   logic [7:0] data_d  = 8'hFF;
   logic       rd_d, tx_d, busy_d;

   fifo_serial_tx dut_def (
      .i_clk(clk), .i_rst(rst), .i_empty(empty_d), .i_data(data_d),
      .o_rd(rd_d), .o_tx(tx_d), .o_busy(busy_d)
   );

   // Frame-timeline model: p counts cycles since leaving idle (0 settle, 1 pop, 2.. serial bits)
   logic       m_act  = 1'b0;
   int         m_p    = 0;
   logic [7:0] m_byte = 8'h00;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act <= 1'b0;
         m_p   <= 0;
      end else if (!m_act) begin
         if (!f_empty) begin
            m_act <= 1'b1;
            m_p   <= 0;
         end
      end else begin
         if (m_p == 1) m_byte <= f_data;
         if (m_p + 1 == 2 + 10 * BD) m_act <= 1'b0;
         m_p <= m_p + 1;
      end
   end

   function automatic logic exp_tx(input logic act, input int p, input logic [7:0] b);
      int k;
      if (!act || p < 2) return 1'b1;
      k = (p - 2) / BD;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return b[k-1];
   endfunction

   always @(negedge clk) begin
      chk("cycle_outs", {29'd0, tx1, rd1, busy1},
          {29'd0, exp_tx(m_act, m_p, m_byte), (m_act && m_p == 1), m_act});
   end

   int rd_log[$];
   always @(negedge clk) if (rd1) rd_log.push_back(cyc);

   task automatic push(input logic [7:0] b);
      wr_byte = b;
      wr_en   = 1'b1;
      @(posedge clk);
      #1;
      wr_en   = 1'b0;
   endtask

   task automatic grab(output logic [9:0] bits, output int st);
      int n;
      n    = 0;
      bits = '1;
      st   = -1;
      @(negedge clk);
      while (tx1 !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (tx1 !== 1'b0) begin
         chk("start_bit_timeout", {31'd0, tx1}, 32'd0);
         return;
      end
      st = cyc;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) repeat (BD) @(negedge clk);
         bits[k] = tx1;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy1 !== 1'b0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, busy1}, 32'd0);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] b1, b2;
      int         s1, s2, hi, rds, b0, w, lowc, fc;

      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_outs", {29'd0, tx1, rd1, busy1}, {29'd0, 3'b100});
      rst = 1'b0;

      // empty FIFO: line idle, no pops
      hi = 0; rds = 0;
      repeat (100) begin
         @(negedge clk);
         if (tx1 === 1'b1 && busy1 === 1'b0) hi++;
         if (rd1 !== 1'b0) rds++;
      end
      chk("empty_idle", hi, 100);
      chk("empty_no_rd", rds, 0);

      // registered-read FIFO, byte written into an empty FIFO
      reg_mode = 1'b1;
      rd_log.delete();
      push(8'h81);
      b0 = -1;
      for (int i = 0; i < 10 && b0 < 0; i++) begin
         @(negedge clk);
         if (busy1 === 1'b1) b0 = cyc;
      end
      grab(b1, s1);
      chk("reg_frame", {22'd0, b1}, {22'd0, 1'b1, 8'h81, 1'b0});
      chk("reg_model_byte", {24'd0, m_byte}, 32'h81);
      chk("reg_rd_count", rd_log.size(), 1);
      chk("reg_settle_gap", (rd_log.size() > 0) ? rd_log[0] - b0 : -1, 1);
      chk("reg_start_lat", s1 - b0, 2);
      wait_idle();
      reg_mode = 1'b0;

      // single byte 0x55
      rd_log.delete();
      push(8'h55);
      grab(b1, s1);
      chk("frame_55", {22'd0, b1}, {22'd0, 10'b1010101010});
      wait_idle();
      chk("rd_count_55", rd_log.size(), 1);

      // back-to-back 0xA3, 0x0F
      rd_log.delete();
      push(8'hA3);
      push(8'h0F);
      grab(b1, s1);
      grab(b2, s2);
      chk("frame_a3", {22'd0, b1}, {22'd0, 1'b1, 8'hA3, 1'b0});
      chk("frame_0f", {22'd0, b2}, {22'd0, 1'b1, 8'h0F, 1'b0});
      chk("frame_period", s2 - s1, 10 * BD + 3);
      wait_idle();
      chk("b2b_rd_count", rd_log.size(), 2);
      chk("b2b_rd_gap", (rd_log.size() == 2) ? rd_log[1] - rd_log[0] : -1, 43);

      // reset during data bit 3 of 0x00
      push(8'h00);
      w = 0;
      while (!(m_act && m_p == 2 + 4 * BD + 1) && w < 60) begin
         @(posedge clk);
         #1;
         w++;
      end
      chk("reach_bit3", {31'd0, tx1}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_async_tx", {31'd0, tx1}, 32'd1);
      chk("rst_async_busy", {31'd0, busy1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx1 === 1'b1 && busy1 === 1'b0 && rd1 === 1'b0) hi++;
      end
      chk("post_rst_idle", hi, 20);
      rd_log.delete();
      push(8'h3C);
      grab(b1, s1);
      chk("frame_after_rst", {22'd0, b1}, {22'd0, 1'b1, 8'h3C, 1'b0});
      wait_idle();
      chk("rd_after_rst", rd_log.size(), 1);

      // default baud divider, byte 0xFF
      @(negedge clk);
      empty_d = 1'b0;
      w = 0;
      while (rd_d !== 1'b1 && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("def_rd_seen", {31'd0, rd_d}, 32'd1);
      empty_d = 1'b1;
      w = 0;
      while (tx_d !== 1'b0 && w < 10) begin
         @(negedge clk);
         w++;
      end
      lowc = 0;
      while (tx_d === 1'b0 && lowc < 5000) begin
         lowc++;
         @(negedge clk);
      end
      chk("def_start_len", lowc, 416);
      fc = lowc; rds = 0;
      while (busy_d === 1'b1 && fc < 5000) begin
         if (rd_d !== 1'b0) rds++;
         fc++;
         @(negedge clk);
      end
      chk("def_frame_len", fc, 4160);
      chk("def_no_rd", rds, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Drains a synchronous FIFO from its read side and serializes each byte as asynchronous 8N1 serial on a single line: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Placed between the FIFO's read port (empty/rd/data) and the board's serial TX pin.
- The FIFO's write side stays with the producer. This block is the FIFO's consumer and the serial link's transmitter.

Parameters:
- CLK_FREQ, 48_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate in bits/s.
- BAUD_DIV, CLK_FREQ/BAUD_RATE (integer truncation, 416 at defaults): clock cycles per serial bit. Must be ≥ 2. Overridable directly for simulation.

Ports:
- i_clk, input, 1: system clock. All logic is on the rising edge.
- i_rst, input, 1: asynchronous, active-high reset.
- i_empty, input, 1: FIFO empty flag.
- i_data, input, 8: FIFO read data. May be a combinational or registered (BRAM) read.
- o_rd, output, 1: FIFO read request. One-cycle pulse pops one byte.
- o_tx, output, 1: serial line, idle high. Registered output.
- o_busy, output, 1: high whenever state ≠ IDLE.

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-high (i_rst).
- Reset values, applied immediately on i_rst assertion:
  - state = IDLE
  - o_tx = 1
  - o_rd = 0
  - o_busy = 0
  - baud counter = 0
  - bit index = 0
  - shift register = 0
- State machine:
  - IDLE: o_tx = 1. If i_empty = 0 → SETTLE.
  - SETTLE (1 cycle): no pop. Lets registered-read FIFO data settle, including the read-during-write case when the FIFO has just gone non-empty.
  - LOAD (1 cycle): o_rd = 1, and i_data is captured into the shift register on the same edge. → START.
  - START: o_tx = 0 for exactly BAUD_DIV cycles → DATA.
  - DATA: o_tx = shift[0] for BAUD_DIV cycles per bit, then shift right. Bit index counts 0..7; after the bit-7 period ends → STOP.
  - STOP: o_tx = 1 for exactly BAUD_DIV cycles → IDLE.
- o_rd is decoded from state == LOAD only:
  - never high for more than one consecutive cycle;
  - never high while i_empty = 1 (FIFO gating also covers this);
  - exactly one pop per frame.
- Latency:
  - i_empty falls in cycle T (sampled at edge T+1) → o_rd high in cycle T+2 → o_tx falls at edge T+3.
  - Frame length: 10·BAUD_DIV cycles of o_tx.
  - Back-to-back frames: IDLE + SETTLE + LOAD add 3 extra high cycles between the end of a stop bit and the next start bit. Minimum frame period is 10·BAUD_DIV + 3 cycles.
- Baud counter:
  - Width is clog2(BAUD_DIV).
  - Reloads to 0 on each bit boundary and on every state entry.
  - No drift accumulates across bits.
- i_empty is ignored outside IDLE. Bytes written during a frame wait in the FIFO.
- i_data is sampled only in LOAD. Changes on i_data at any other time have no effect.
- Reset mid-frame: o_tx returns high asynchronously. A byte already popped is discarded and not retransmitted. After i_rst deasserts, the block restarts from IDLE.
- No FIFO overflow/underflow handling here. The FIFO flags govern.

Test Plan:
- BAUD_DIV=4, FIFO holds 0x55 → o_rd is one pulse. o_tx after LOAD, in 4-cycle groups: 0,1,0,1,0,1,0,1,0,1, then high. o_busy is high from SETTLE through the last STOP cycle.
- BAUD_DIV=4, FIFO holds 0xA3, 0x0F back-to-back → two frames: bits 0|1,1,0,0,0,1,0,1|1 then 0|1,1,1,1,0,0,0,0|1. Exactly 3 high cycles between frames. Exactly two o_rd pulses, 43 cycles apart (10·4 + 3).
- Empty FIFO held 100 cycles after reset → o_tx = 1, o_rd = 0, o_busy = 0 throughout.
- Registered-read FIFO model, byte 0x81 written into an empty FIFO → captured byte is 0x81, not the stale RAM word. The SETTLE cycle is observed before o_rd.
- Assert i_rst during DATA bit 3 of 0x00 → o_tx = 1 in the same cycle, before the next edge. After release, no frame starts until i_empty = 0. The next frame transmits the next FIFO byte.
- BAUD_DIV at default (416), byte 0xFF → start bit low for exactly 416 cycles. Total frame is 4160 cycles. No o_rd pulse during the frame.
